pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset (bits [1:0] SHALL be 0).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 redirect_valid  input  1  taken branch/jump from the immediate-address stage.
REQ-005 redirect_pc  input  32  branch/jump target (that stage's iadd_out: rs1+imm or pc+imm).
REQ-006 imem_req  output  1  instruction-memory request.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_gnt  input  1  memory accepted request this cycle.
REQ-009 imem_rvalid  input  1  read data valid this cycle.
REQ-010 imem_rdata  input  32  fetched instruction.
REQ-011 if_valid  output  1  fetched instruction available to decode.
REQ-012 if_pc  output  32  PC of if_instr.
REQ-013 if_instr  output  32  fetched instruction.
REQ-014 if_ready  input  1  decode accepts if_instr this cycle.
REQ-015 misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, OUT; at most one memory request SHALL be outstanding.
REQ-017 IDLE SHALL go to REQ unconditionally on the next cycle.
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_gnt=1 SHALL move to WAIT, otherwise the block SHALL stay in REQ.
REQ-019 In WAIT, imem_rvalid=1 with kill=0 SHALL capture if_instr<=imem_rdata and if_pc<=pc, set pc<=pc+4 and go to OUT.
REQ-020 In OUT, if_valid SHALL be 1 and if_pc/if_instr SHALL be held stable until if_ready=1; if_ready=1 SHALL go to REQ with if_valid=0 from the next cycle.
REQ-021 imem_req SHALL be 0 outside REQ; if_valid SHALL be 0 outside OUT.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 redirect_valid=1 in any state SHALL load pc<={redirect_pc[31:2],2'b00} and SHALL have priority over imem_rvalid, imem_gnt and if_ready.
REQ-024 misalign_err SHALL be 1 for exactly the cycle after redirect_valid=1 with redirect_pc[1:0]!=0; the aligned redirect SHALL still be taken.
REQ-025 Redirect in REQ with imem_gnt=0: stay in REQ; imem_addr SHALL show the new pc the next cycle (the memory accepts address change while gnt=0).
REQ-026 Redirect in REQ with imem_gnt=1, or in WAIT without imem_rvalid: set kill=1; go to or stay in WAIT.
REQ-027 In WAIT with kill=1, imem_rvalid=1 SHALL discard the data, clear kill, leave pc unchanged and go to REQ.
REQ-028 Redirect in WAIT with imem_rvalid=1 in the same cycle: discard the data, keep kill=0, go to REQ.
REQ-029 Redirect in OUT (including same-cycle if_ready=1): if_valid SHALL be 0 next cycle and the FSM SHALL go to REQ.
REQ-030 Redirect in IDLE: go to REQ with the new pc.
REQ-031 Latency: with imem_gnt immediate and imem_rvalid on the cycle after the grant, if_valid SHALL assert 2 cycles after REQ is entered.

Reset
REQ-032 rst=1 SHALL set state=IDLE, pc=RESET_PC, kill=0, if_pc=0, if_instr=0 and misalign_err=0.
REQ-033 While rst=1, imem_req=0 and if_valid=0; rst SHALL override redirect_valid and all memory inputs.
REQ-034 rst asserted mid-transaction SHALL abandon it; a later imem_rvalid for that request SHALL be ignored (kill=1 only if in WAIT at reset? no: the memory interface is reset together with this block).

Verification
REQ-035 Reset release, memory grants and responds immediately with rdata 32'h00000013 -> imem_addr=0, then if_valid with if_pc=0, if_instr=32'h00000013; next imem_addr=32'h4.
REQ-036 if_ready=0 for 3 cycles in OUT -> if_valid, if_pc and if_instr stable; imem_req=0 throughout.
REQ-037 redirect_pc=32'h98765441 in WAIT, rvalid next cycle -> data dropped, if_valid stays 0, misalign_err=1 for one cycle, next imem_addr=32'h98765440.
REQ-038 redirect_pc=32'h12345678 while in OUT with if_ready=1 -> if_valid=0 next cycle, next imem_addr=32'h12345678, misalign_err=0.
REQ-039 RESET_PC=32'hFFFFFFFC, one fetch completes -> if_pc=32'hFFFFFFFC, next imem_addr=32'h00000000.
REQ-040 imem_gnt held 0 for 4 cycles in REQ -> imem_req=1 and imem_addr constant; no state change.

Source files
------------

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: groups the redirect, instruction-memory and decode-side signals of pc_fetch.
// Ports: master = fetch unit (drives imem_req/imem_addr/if_*/misalign_err);
//        slave  = surrounding pipeline + memory (drives redirect_*, imem_gnt/rvalid/rdata, if_ready).
interface pc_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        misalign_err;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program counter + single-outstanding instruction fetch FSM (IDLE/REQ/WAIT/OUT).
// Latency: if_valid asserts 2 cycles after REQ is entered with an immediate grant and next-cycle rvalid.
// Backpressure: holds the fetched instruction in OUT until if_ready; no new request is issued meanwhile.
// Ports: clk, rst (sync, active-high); bus (pc_fetch_if.master) carries redirect, imem and decode signals.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  pc_fetch_if.master    bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        kill_q;       // response in flight belongs to a redirected-away request
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic        misalign_q;
  logic        imem_req_q;   // registered copy of (state == S_REQ)
  logic        if_valid_q;   // registered copy of (state == S_OUT)

  logic [31:0] pc_inc_d;
  logic [31:0] redir_pc_d;

  assign pc_inc_d   = pc_q + 32'd4;  // wraps naturally modulo 2^32
  assign redir_pc_d = {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
      misalign_q <= 1'b0;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
    end else begin
      misalign_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

      if (bus.redirect_valid) begin
        // Redirect beats every memory/decode handshake; only the kill bookkeeping
        // depends on whether a request is still in flight.
        pc_q <= redir_pc_d;
        case (state_q)
          S_REQ: begin
            if (bus.imem_gnt) begin
              state_q    <= S_WAIT;
              kill_q     <= 1'b1;
              imem_req_q <= 1'b0;
            end else begin
              state_q    <= S_REQ;
              imem_req_q <= 1'b1;
            end
            if_valid_q <= 1'b0;
          end
          S_WAIT: begin
            if (bus.imem_rvalid) begin
              // Data arriving this cycle is dropped; nothing remains in flight.
              state_q    <= S_REQ;
              kill_q     <= 1'b0;
              imem_req_q <= 1'b1;
            end else begin
              state_q    <= S_WAIT;
              kill_q     <= 1'b1;
              imem_req_q <= 1'b0;
            end
            if_valid_q <= 1'b0;
          end
          default: begin  // S_IDLE, S_OUT
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
            if_valid_q <= 1'b0;
          end
        endcase
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
            if_valid_q <= 1'b0;
          end
          S_REQ: begin
            if (bus.imem_gnt) begin
              state_q    <= S_WAIT;
              imem_req_q <= 1'b0;
            end else begin
              state_q    <= S_REQ;
              imem_req_q <= 1'b1;
            end
            if_valid_q <= 1'b0;
          end
          S_WAIT: begin
            if (bus.imem_rvalid) begin
              if (kill_q) begin
                // Stale response: drop it and refetch from the redirected pc.
                state_q    <= S_REQ;
                kill_q     <= 1'b0;
                imem_req_q <= 1'b1;
                if_valid_q <= 1'b0;
              end else begin
                state_q    <= S_OUT;
                if_instr_q <= bus.imem_rdata;
                if_pc_q    <= pc_q;
                pc_q       <= pc_inc_d;
                imem_req_q <= 1'b0;
                if_valid_q <= 1'b1;
              end
            end else begin
              state_q    <= S_WAIT;
              imem_req_q <= 1'b0;
              if_valid_q <= 1'b0;
            end
          end
          S_OUT: begin
            if (bus.if_ready) begin
              state_q    <= S_REQ;
              imem_req_q <= 1'b1;
              if_valid_q <= 1'b0;
            end else begin
              state_q    <= S_OUT;
              imem_req_q <= 1'b0;
              if_valid_q <= 1'b1;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            imem_req_q <= 1'b0;
            if_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.imem_addr    = pc_q;
  assign bus.if_valid     = if_valid_q;
  assign bus.if_pc        = if_pc_q;
  assign bus.if_instr     = if_instr_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed vector table for pc_fetch plus a hand-written wrap-around sequence.
// Each row drives inputs before a rising edge and checks the registered outputs 1 ns after it.
module tb_pc_fetch;

  logic clk;
  logic rst;

  pc_fetch_if bus1 ();
  pc_fetch_if bus2 ();

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        gnt;
    logic        rval;
    logic [31:0] rdata;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        mis;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic gnt, input logic rval, input logic [31:0] rdata,
                     input logic rdy, input logic req, input logic [31:0] addr,
                     input logic vld, input logic [31:0] ipc, input logic [31:0] instr,
                     input logic mis);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rval = rval; v.rdata = rdata;
    v.rdy = rdy; v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc; v.instr = instr;
    v.mis = mis;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus1.redirect_valid = 0; bus1.redirect_pc = 0; bus1.imem_gnt = 0;
    bus1.imem_rvalid = 0; bus1.imem_rdata = 0; bus1.if_ready = 0;
    bus2.redirect_valid = 0; bus2.redirect_pc = 0; bus2.imem_gnt = 0;
    bus2.imem_rvalid = 0; bus2.imem_rdata = 0; bus2.if_ready = 0;

    //   rst rv rpc           gnt rval rdata         rdy | req addr          vld if_pc         instr         mis
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0); // 0 reset
    add(1, 1, 32'h5557,     1, 1, 32'h77,       1,   0, 32'h0,        0, 32'h0,        32'h0,        0); // 1 rst overrides
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        32'h0,        0); // 2 IDLE->REQ
    add(0, 0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0); // 3 grant
    add(0, 0, 32'h0,        0, 1, 32'h13,       0,   0, 32'h4,        1, 32'h0,        32'h13,       0); // 4 OUT
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h4,        1, 32'h0,        32'h13,       0); // 5 stall
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h4,        1, 32'h0,        32'h13,       0); // 6 stall
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h4,        1, 32'h0,        32'h13,       0); // 7 stall
    add(0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h4,        0, 32'h0,        32'h13,       0); // 8 accept
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h4,        0, 32'h0,        32'h13,       0); // 9 no gnt
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h4,        0, 32'h0,        32'h13,       0); // 10
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h4,        0, 32'h0,        32'h13,       0); // 11
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h4,        0, 32'h0,        32'h13,       0); // 12
    add(0, 0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h4,        0, 32'h0,        32'h13,       0); // 13 WAIT
    add(0, 1, 32'h98765441, 0, 0, 32'h0,        0,   0, 32'h98765440, 0, 32'h0,        32'h13,       1); // 14 redirect in WAIT
    add(0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0,   1, 32'h98765440, 0, 32'h0,        32'h13,       0); // 15 killed data
    add(0, 0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h98765440, 0, 32'h0,        32'h13,       0); // 16
    add(0, 0, 32'h0,        0, 1, 32'h00A00093, 0,   0, 32'h98765444, 1, 32'h98765440, 32'h00A00093, 0); // 17
    add(0, 1, 32'h12345678, 0, 0, 32'h0,        1,   1, 32'h12345678, 0, 32'h98765440, 32'h00A00093, 0); // 18 redirect in OUT
    add(0, 1, 32'h1000,     0, 0, 32'h0,        0,   1, 32'h1000,     0, 32'h98765440, 32'h00A00093, 0); // 19 redirect REQ no gnt
    add(0, 1, 32'h2000,     1, 0, 32'h0,        0,   0, 32'h2000,     0, 32'h98765440, 32'h00A00093, 0); // 20 redirect REQ+gnt
    add(0, 0, 32'h0,        0, 1, 32'h11111111, 0,   1, 32'h2000,     0, 32'h98765440, 32'h00A00093, 0); // 21 killed data
    add(0, 0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h2000,     0, 32'h98765440, 32'h00A00093, 0); // 22
    add(0, 1, 32'h3002,     0, 1, 32'h22222222, 0,   1, 32'h3000,     0, 32'h98765440, 32'h00A00093, 1); // 23 redirect+rvalid
    add(0, 0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h3000,     0, 32'h98765440, 32'h00A00093, 0); // 24
    add(0, 0, 32'h0,        0, 1, 32'h33333333, 0,   0, 32'h3004,     1, 32'h3000,     32'h33333333, 0); // 25 kill was clear
    add(0, 1, 32'h4000,     0, 0, 32'h0,        0,   1, 32'h4000,     0, 32'h3000,     32'h33333333, 0); // 26 redirect OUT stalled
    add(1, 1, 32'h5000,     1, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0); // 27 mid-txn reset
    add(0, 1, 32'h6000,     0, 0, 32'h0,        0,   1, 32'h6000,     0, 32'h0,        32'h0,        0); // 28 redirect in IDLE
    add(0, 0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h6000,     0, 32'h0,        32'h0,        0); // 29
    add(0, 0, 32'h0,        0, 1, 32'h44,       0,   0, 32'h6004,     1, 32'h6000,     32'h44,       0); // 30

    foreach (vecs[i]) begin
      rst                 = vecs[i].rst;
      bus1.redirect_valid = vecs[i].rv;
      bus1.redirect_pc    = vecs[i].rpc;
      bus1.imem_gnt       = vecs[i].gnt;
      bus1.imem_rvalid    = vecs[i].rval;
      bus1.imem_rdata     = vecs[i].rdata;
      bus1.if_ready       = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("row%0d.imem_req", i),     {31'h0, bus1.imem_req},     {31'h0, vecs[i].req});
      check($sformatf("row%0d.imem_addr", i),    bus1.imem_addr,             vecs[i].addr);
      check($sformatf("row%0d.if_valid", i),     {31'h0, bus1.if_valid},     {31'h0, vecs[i].vld});
      check($sformatf("row%0d.if_pc", i),        bus1.if_pc,                 vecs[i].ipc);
      check($sformatf("row%0d.if_instr", i),     bus1.if_instr,              vecs[i].instr);
      check($sformatf("row%0d.misalign_err", i), {31'h0, bus1.misalign_err}, {31'h0, vecs[i].mis});
    end

    // Wrap-around of pc+4 on a block reset to the top word.
    bus1.redirect_valid = 0; bus1.imem_gnt = 0; bus1.imem_rvalid = 0; bus1.if_ready = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("wrap.reset_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    check("wrap.reset_req", {31'h0, bus2.imem_req}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("wrap.req", {31'h0, bus2.imem_req}, 32'h1);
    check("wrap.req_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    bus2.imem_gnt = 1'b1;
    @(posedge clk); #1;
    check("wrap.wait_req", {31'h0, bus2.imem_req}, 32'h0);
    bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'h0000_0013;
    @(posedge clk); #1;
    bus2.imem_rvalid = 1'b0;
    check("wrap.if_valid", {31'h0, bus2.if_valid}, 32'h1);
    check("wrap.if_pc", bus2.if_pc, 32'hFFFF_FFFC);
    check("wrap.if_instr", bus2.if_instr, 32'h0000_0013);
    check("wrap.next_addr", bus2.imem_addr, 32'h0000_0000);
    bus2.if_ready = 1'b1;
    @(posedge clk); #1;
    check("wrap.refetch_req", {31'h0, bus2.imem_req}, 32'h1);
    check("wrap.refetch_addr", bus2.imem_addr, 32'h0000_0000);
    check("wrap.if_valid_drop", {31'h0, bus2.if_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
